// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-N oversample tick generator for the UART datapaths.
//
// An oversample strobe fires every div_int + div_frac/2^FRAC_W clocks on
// average. Each period is div_int or div_int+1 clocks; the choice comes from
// the carry out of a FRAC_W-bit phase accumulator. Every OVS oversample ticks
// the block emits one mid-bit strobe and one bit strobe. A restart pulse
// realigns the bit phase to a detected start edge.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         count enable; low freezes all state
//   restart    synchronous phase realign (single-cycle pulse)
//   div_int    integer clocks per oversample tick
//   div_frac   fractional clocks per tick, in units of 1/2^FRAC_W
//   os_tick    oversample strobe, one cycle wide
//   mid_tick   strobe on oversample tick OVS/2 of each bit
//   baud_tick  strobe on oversample tick OVS of each bit
//   bit_phase  current oversample index within the bit (0..OVS-1)
//   cfg_err    registered flag, high while div_int == 0
module baud_gen_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OVS    = 16,
  localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              baud_tick,
  output logic [OVS_W-1:0]  bit_phase,
  output logic              cfg_err
);

  localparam logic [OVS_W-1:0] PH_MID  = OVS_W'(OVS/2 - 1);
  localparam logic [OVS_W-1:0] PH_LAST = OVS_W'(OVS - 1);

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              ext;
  logic [OVS_W-1:0]  phase;

  // The terminal test cnt >= div_int-1+ext is evaluated as
  // cnt+1 >= div_int+ext, one bit wider. This form cannot underflow when
  // div_int is 0. A live decrease of div_int ends the current period at once
  // instead of wrapping.
  logic [DIV_W:0]  cnt_p1, lim;
  logic            term;
  logic [FRAC_W:0] frac_sum;
  logic            div_zero;

  always_comb begin
    cnt_p1   = {1'b0, cnt} + {{DIV_W{1'b0}}, 1'b1};
    lim      = {1'b0, div_int} + {{DIV_W{1'b0}}, ext};
    term     = (cnt_p1 >= lim);
    frac_sum = {1'b0, acc} + {1'b0, div_frac};
    div_zero = (div_int == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      ext       <= 1'b0;
      phase     <= '0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err   <= div_zero;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
      if (restart) begin
        // Realign wins over a coinciding terminal count, so no strobe fires.
        cnt   <= '0;
        acc   <= '0;
        ext   <= 1'b0;
        phase <= '0;
      end else if (!div_zero && en) begin
        if (term) begin
          cnt        <= '0;
          {ext, acc} <= frac_sum;   // carry stretches the next period by 1
          os_tick    <= 1'b1;
          mid_tick   <= (phase == PH_MID);
          baud_tick  <= (phase == PH_LAST);
          phase      <= (phase == PH_LAST) ? '0 : phase + OVS_W'(1);
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

  assign bit_phase = phase;

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Programmable fractional-N baud/oversample tick generator for the UART TX/RX datapaths. Produces an oversample strobe at div_int + div_frac/2^FRAC_W clocks per tick, plus a mid-bit strobe and a bit strobe every OVS oversample ticks. A synchronous restart realigns the bit phase to a detected start-bit edge.

Parameters:
DIV_W, 16, width of integer divisor and period counter.
FRAC_W, 4, width of fractional divisor and phase accumulator.
OVS, 16, oversample ticks per bit. Must be even and >= 2. OVS_W = clog2(OVS).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
en  in  1  count enable. Low freezes all state.
restart  in  1  synchronous phase realign, single-cycle pulse.
div_int  in  DIV_W  integer part of clocks per oversample tick.
div_frac  in  FRAC_W  fractional part, in units of 1/2^FRAC_W clock.
os_tick  out  1  oversample strobe, 1 cycle wide.
mid_tick  out  1  strobe at oversample tick OVS/2 of each bit.
baud_tick  out  1  strobe at oversample tick OVS of each bit.
bit_phase  out  OVS_W  current oversample index within bit, 0..OVS-1.
cfg_err  out  1  registered flag, high while div_int == 0.

Behaviour:
- Internal state: cnt[DIV_W], acc[FRAC_W], ext (1 bit), phase[OVS_W].
- Reset (async, rst=1): cnt, acc, ext and phase clear to 0. All outputs are 0.
- All outputs are registered. A strobe is visible in the cycle after the clock edge at which the terminal condition is met.
- Priority at each edge: rst, then restart, then cfg_err, then en.
- restart=1: cnt, acc, ext and phase clear to 0. All strobes are 0 that cycle, including a coinciding terminal count. Applies regardless of en.
- cfg_err: cfg_err <= (div_int == 0).
  - While div_int == 0, state holds and no strobes are issued.
  - Counting resumes from the held state once div_int != 0.
- en=0: state frozen, strobes 0.
- Enabled cycle, non-terminal: cnt <= cnt+1 and strobes are 0.
- Terminal condition: cnt >= div_int-1+ext. The >= comparison makes a live divisor decrease end the current period immediately, with no wrap. On a terminal edge:
  - cnt <= 0.
  - {ext,acc} <= acc + div_frac, a (FRAC_W+1)-bit sum. Carry-out lengthens the next period by one clock.
  - os_tick <= 1.
  - mid_tick <= (phase == OVS/2-1).
  - baud_tick <= (phase == OVS-1).
  - phase <= (phase == OVS-1) ? 0 : phase+1.
- Resulting timing:
  - Oversample period is div_int+ext clocks.
  - Long-run average is div_int + div_frac/2^FRAC_W.
  - First os_tick after reset or restart follows the div_int-th enabled edge, since ext=0.
- bit_phase = phase, registered. It reads 0 after reset or restart.
- div_int and div_frac are sampled live on every edge. Software changes them only with en=0 or together with restart. Mid-period changes are safe (no wrap, no lockup) but the period in progress is undefined.
- Reset asserted mid-bit aborts immediately. Outputs drop to 0 asynchronously.

Test Plan:
1. div_int=3, div_frac=0, OVS=16, en=1 after reset → os_tick every 3 clocks, first after 3rd edge. mid_tick on 8th os_tick. baud_tick on 16th os_tick, then every 48 clocks. bit_phase steps 0..15.
2. div_int=3, div_frac=8 (0.5), FRAC_W=4 → os_tick intervals 3,3,4,3,4,3,4…, averaging 3.5 clocks.
3. div_int=325, div_frac=8, OVS=16 (50 MHz / 9600 baud) → first baud_tick 5207 clocks after start. Subsequent baud_tick spacing is exactly 5208 clocks. mid_tick is 8 os_ticks after each bit start.
4. restart pulsed at bit_phase=5, and separately on an edge where the terminal count is met → no strobe that cycle. bit_phase=0. Next os_tick exactly div_int clocks later.
5. en low for 10 clocks mid-period → cnt, phase and acc frozen, no strobes. On en high, the period completes with the remaining count only. div_int=0 → cfg_err=1 and no ticks. Setting div_int=3 clears cfg_err next cycle and ticks resume.
6. rst asserted asynchronously between clock edges mid-bit → all outputs 0 immediately. After release, the first os_tick follows div_int enabled edges.
